// File: rtl/counter_pkg.sv
// Shared constants for the LVC-style up/down counter family.
// Width-generic values are stored at MAX_WIDTH and cast down to the instance
// width by each counter, so a single package serves every width.
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 64;

    localparam logic [MAX_WIDTH-1:0] ZERO     = '0;
    localparam logic [MAX_WIDTH-1:0] ONE      = MAX_WIDTH'(1);
    // Truncating this to WIDTH bits gives the WIDTH-bit all-ones value.
    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/down_counter_lvc191.sv
// Presettable, cascadable binary down counter with auto-reload and a
// registered borrow pulse; usable as a modulo-N divider or interval timer.
//
// Ports:
//   CP   clock, rising edge
//   CR   asynchronous active-low clear (Q, reload register, BO)
//   PE   synchronous active-low parallel load of D into Q and reload register
//   CEP  count enable (parallel)
//   CET  count enable (trickle), also gates TC
//   AR   1: reload from reload register at terminal count, 0: wrap to all-ones
//   D    parallel data
//   Q    registered count
//   TC   combinational terminal count / borrow-out for cascading
//   BO   registered one-cycle borrow pulse
module down_counter_lvc191
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             PE,
    input  logic             CEP,
    input  logic             CET,
    input  logic             AR,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             BO
);

    localparam logic [WIDTH-1:0] Q_ZERO = WIDTH'(ZERO);
    localparam logic [WIDTH-1:0] Q_ONE  = WIDTH'(ONE);
    localparam logic [WIDTH-1:0] Q_ONES = WIDTH'(ALL_ONES);

    logic [WIDTH-1:0] rv;
    logic             ce;
    logic             q_is_zero;

    // Count step: decrement, or at zero either reload or wrap to all-ones.
    function automatic logic [WIDTH-1:0] next_q(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] reload,
        input logic             auto_reload
    );
        if (q == Q_ZERO) begin
            return auto_reload ? reload : Q_ONES;
        end
        return q - Q_ONE;
    endfunction

    assign ce        = CET & CEP;
    assign q_is_zero = (Q == Q_ZERO);

    // Borrow-out for the next stage; deliberately independent of CEP.
    assign TC = CET & PE & q_is_zero;

    // Count, load and reload state with asynchronous clear.
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            Q  <= Q_ZERO;
            rv <= Q_ZERO;
            BO <= 1'b0;
        end else if (!PE) begin
            Q  <= D;
            rv <= D;
            BO <= 1'b0;
        end else if (ce) begin
            Q  <= next_q(Q, rv, AR);
            BO <= q_is_zero;
        end else begin
            BO <= 1'b0;
        end
    end

endmodule

// File: tb/tb_down_counter_lvc191.sv
module tb_down_counter_lvc191;

    // Single 4-bit instance
    logic       cp = 1'b0;
    logic       cr, pe, cep, cet, ar;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, bo;

    // Two-stage 8-bit cascade
    logic       c_pe, c_cep, c_cet;
    logic [7:0] c_d;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, c_tc, bo_lo, bo_hi;

    // Reference model state
    int mq, mrv;
    bit mbo;
    int cq;
    bit cbo_lo, cbo_hi;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 cp = ~cp;

    down_counter_lvc191 #(.WIDTH(4)) dut (
        .CP(cp), .CR(cr), .PE(pe), .CEP(cep), .CET(cet), .AR(ar),
        .D(d), .Q(q), .TC(tc), .BO(bo)
    );

    down_counter_lvc191 #(.WIDTH(4)) u_lo (
        .CP(cp), .CR(cr), .PE(c_pe), .CEP(c_cep), .CET(c_cet), .AR(1'b0),
        .D(c_d[3:0]), .Q(q_lo), .TC(tc_lo), .BO(bo_lo)
    );

    down_counter_lvc191 #(.WIDTH(4)) u_hi (
        .CP(cp), .CR(cr), .PE(c_pe), .CEP(c_cep), .CET(tc_lo), .AR(1'b0),
        .D(c_d[7:4]), .Q(q_hi), .TC(c_tc), .BO(bo_hi)
    );

    // Expected terminal counts from the model
    function automatic bit exp_tc();
        return cet && pe && (mq == 0);
    endfunction

    function automatic bit exp_ctc();
        return c_cet && c_pe && (cq == 0);
    endfunction

    // Advance both models over one rising edge, then wait to the falling edge.
    task automatic tick();
        @(posedge cp);
        if (!cr) begin
            mq = 0; mrv = 0; mbo = 0;
        end else if (!pe) begin
            mq = int'(d); mrv = int'(d); mbo = 0;
        end else if (cet && cep) begin
            if (mq == 0) begin
                mq  = ar ? mrv : 15;
                mbo = 1;
            end else begin
                mq  = mq - 1;
                mbo = 0;
            end
        end else begin
            mbo = 0;
        end

        if (!cr) begin
            cq = 0; cbo_lo = 0; cbo_hi = 0;
        end else if (!c_pe) begin
            cq = int'(c_d); cbo_lo = 0; cbo_hi = 0;
        end else if (c_cep && c_cet) begin
            cbo_lo = (cq % 16) == 0;
            cbo_hi = (cq == 0);
            cq     = (cq + 255) % 256;
        end else begin
            cbo_lo = 0; cbo_hi = 0;
        end
        @(negedge cp);
    endtask

    task automatic test_reset();
        cr = 1'b0; pe = 1'b1; cep = 1'b0; cet = 1'b1; ar = 1'b0; d = 4'h0;
        c_pe = 1'b1; c_cep = 1'b0; c_cet = 1'b1; c_d = 8'h00;
        mq = 0; mrv = 0; mbo = 0; cq = 0; cbo_lo = 0; cbo_hi = 0;
        tick();
        tick();
        n_cmp++;
        if (q !== 4'h0 || bo !== 1'b0 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: q=%h bo=%b tc=%b required q=0 bo=0 tc=1", q, bo, tc);
        end
        // Run into a count with a pending borrow, then clear asynchronously.
        cr = 1'b1; pe = 1'b0; d = 4'h0;
        tick();
        pe = 1'b1; cep = 1'b1;
        tick();
        cep = 1'b0; pe = 1'b0; d = 4'h9;
        tick();
        pe = 1'b1;
        n_cmp++;
        if (q !== 4'h9) begin
            n_fail++;
            $display("FAIL reset_preload: q=%h required 9", q);
        end
        cr = 1'b0;
        mq = 0; mrv = 0; mbo = 0; cq = 0;
        #1;
        n_cmp++;
        if (q !== 4'h0 || bo !== 1'b0 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: q=%h bo=%b tc=%b required q=0 bo=0 tc=1", q, bo, tc);
        end
        tick();
        cr = 1'b1;
    endtask

    task automatic test_load_count();
        int seq [4] = '{2, 1, 0, 15};
        pe = 1'b0; d = 4'h3; cep = 1'b1; cet = 1'b1; ar = 1'b0;
        tick();
        n_cmp++;
        if (q !== 4'h3 || bo !== 1'b0) begin
            n_fail++;
            $display("FAIL load: q=%h bo=%b required q=3 bo=0", q, bo);
        end
        pe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (q !== 4'(seq[i]) || q !== 4'(mq) || bo !== (i == 3) || tc !== exp_tc()) begin
                n_fail++;
                $display("FAIL count_step%0d: q=%h bo=%b tc=%b required q=%h bo=%b tc=%b",
                         i, q, bo, tc, 4'(seq[i]), (i == 3), exp_tc());
            end
        end
    endtask

    task automatic test_autoreload();
        int pulses = 0;
        pe = 1'b0; d = 4'h2; ar = 1'b1; cep = 1'b1; cet = 1'b1;
        tick();
        pe = 1'b1;
        // Loaded value 2 is the first element; 8 more enabled edges follow.
        for (int i = 1; i < 9; i++) begin
            tick();
            if (bo) pulses++;
            n_cmp++;
            if (q !== 4'(2 - (i % 3)) || bo !== mbo || tc !== exp_tc()) begin
                n_fail++;
                $display("FAIL reload_step%0d: q=%h bo=%b tc=%b required q=%h bo=%b tc=%b",
                         i, q, bo, tc, 4'(2 - (i % 3)), mbo, exp_tc());
            end
        end
        n_cmp++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL reload_pulses: got %0d required 2", pulses);
        end
    endtask

    task automatic test_enables();
        pe = 1'b0; d = 4'h0; ar = 1'b0;
        tick();
        pe = 1'b1; cep = 1'b0; cet = 1'b1;
        tick();
        n_cmp++;
        if (q !== 4'h0 || bo !== 1'b0 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_cep0: q=%h bo=%b tc=%b required q=0 bo=0 tc=1", q, bo, tc);
        end
        cet = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cep = i[0];
            tick();
            n_cmp++;
            if (q !== 4'h0 || bo !== 1'b0 || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cet0_cep%0d: q=%h bo=%b tc=%b required q=0 bo=0 tc=0",
                         i, q, bo, tc);
            end
        end
        cet = 1'b1;
    endtask

    task automatic test_priority();
        pe = 1'b0; d = 4'h0;
        tick();
        pe = 1'b0; d = 4'h7; cep = 1'b1; cet = 1'b1;
        tick();
        n_cmp++;
        if (q !== 4'h7 || bo !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_borrow: q=%h bo=%b required q=7 bo=0", q, bo);
        end
        cr = 1'b0; d = 4'h5;
        tick();
        n_cmp++;
        if (q !== 4'h0 || bo !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_over_load: q=%h bo=%b required q=0 bo=0", q, bo);
        end
        cr = 1'b1; pe = 1'b1;
        // First enabled edge after release wraps from 0.
        tick();
        n_cmp++;
        if (q !== 4'hF || bo !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_after_clear: q=%h bo=%b required q=f bo=1", q, bo);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cr  = ($urandom_range(0, 39) != 0);
            pe  = ($urandom_range(0, 9) != 0);
            cep = ($urandom_range(0, 3) != 0);
            cet = ($urandom_range(0, 4) != 0);
            ar  = $urandom_range(0, 1) == 1;
            d   = 4'($urandom_range(0, 15));
            tick();
            n_cmp++;
            if (q !== 4'(mq) || bo !== mbo || tc !== exp_tc()) begin
                n_fail++;
                $display("FAIL random%0d: q=%h bo=%b tc=%b required q=%h bo=%b tc=%b",
                         i, q, bo, tc, 4'(mq), mbo, exp_tc());
            end
        end
        cr = 1'b1;
    endtask

    task automatic test_cascade();
        pe = 1'b1; cep = 1'b0;
        c_pe = 1'b0; c_d = 8'h01; c_cep = 1'b1; c_cet = 1'b1;
        tick();
        c_pe = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({q_hi, q_lo} !== ((i == 0) ? 8'h00 : 8'hFF) || c_tc !== (i == 0)) begin
                n_fail++;
                $display("FAIL cascade_step%0d: q=%h tc=%b required q=%h tc=%b",
                         i, {q_hi, q_lo}, c_tc, (i == 0) ? 8'h00 : 8'hFF, (i == 0));
            end
        end
        for (int i = 0; i < 80; i++) begin
            c_pe  = ($urandom_range(0, 15) != 0);
            c_cep = ($urandom_range(0, 3) != 0);
            c_cet = ($urandom_range(0, 7) != 0);
            c_d   = 8'($urandom_range(0, 20));
            tick();
            n_cmp++;
            if ({q_hi, q_lo} !== 8'(cq) || c_tc !== exp_ctc()
                || bo_lo !== cbo_lo || bo_hi !== cbo_hi) begin
                n_fail++;
                $display("FAIL cascade_rand%0d: q=%h tc=%b bo=%b%b required q=%h tc=%b bo=%b%b",
                         i, {q_hi, q_lo}, c_tc, bo_hi, bo_lo, 8'(cq), exp_ctc(), cbo_hi, cbo_lo);
            end
        end
    endtask

    initial begin
        @(negedge cp);
        test_reset();
        test_load_count();
        test_autoreload();
        test_enables();
        test_priority();
        test_random();
        test_cascade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
